// File: rtl/matriz_pkg.sv
// Shared constants for the LED-matrix cursor puzzle: button indices and the
// per-level victory target. Optional cursor blink is enabled by MATRIZ_CURSOR_BLINK_EN.
package matriz_pkg;

    localparam int NUM_BOTOES = 6;
    localparam int BTN_CIMA   = 0;
    localparam int BTN_BAIXO  = 1;
    localparam int BTN_ESQ    = 2;
    localparam int BTN_DIR    = 3;
    localparam int BTN_TOGGLE = 4;
    localparam int BTN_CLEAR  = 5;

    // Rows counted from row 0 that must be fully lit; 0 means the level cannot be won.
    function automatic int linhas_alvo(input logic [2:0] nivel, input int linhas);
        int k;
        k = 2 * int'(nivel) + 1;
        if (k > linhas + 1) begin
            return 0;
        end else if (k > linhas) begin
            return linhas;
        end else begin
            return k;
        end
    endfunction

endpackage

// File: rtl/matriz_leds_cursor_debounce.sv
// Button conditioner: 2-FF synchroniser, counter debouncer and a single
// registered pulse on each accepted press.
module debounce_botao #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic pulso
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_estavel;
    logic          r_estavel_ant;
    logic          r_pulso;
    logic [CW-1:0] r_cnt;

    // A new level is taken only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_estavel     <= 1'b0;
            r_estavel_ant <= 1'b0;
            r_pulso       <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_sync1       <= in;
            r_sync2       <= r_sync1;
            r_estavel_ant <= r_estavel;
            r_pulso       <= r_estavel & ~r_estavel_ant;
            if (r_sync2 != r_estavel) begin
                if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                    r_estavel <= r_sync2;
                    r_cnt     <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign pulso = r_pulso;

endmodule

// File: rtl/matriz_leds_cursor.sv
// Lights-out style LED-matrix controller with button-driven cursor and row scan.
// Define MATRIZ_CURSOR_BLINK_EN to blink the cursor cell on the display.
module matriz_leds_cursor
    import matriz_pkg::*;
#(
    parameter int LINHAS     = 8,
    parameter int COLUNAS    = 8,
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_CYCLES = 50000,
    parameter int BLINK_DIV  = 250000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [5:0]                 botoes,
    input  logic [2:0]                 nivel,
    output logic                       nivel_concluido,
    output logic [COLUNAS-1:0]         colunas,
    output logic [LINHAS-1:0]          linhas,
    output logic [$clog2(LINHAS)-1:0]  cursor_linha,
    output logic [$clog2(COLUNAS)-1:0] cursor_coluna
);

    localparam int LW = $clog2(LINHAS);
    localparam int CW = $clog2(COLUNAS);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    if (LINHAS < 2 || LINHAS > 16 || COLUNAS < 2 || COLUNAS > 16 ||
        SCAN_DIV < 1 || DEB_CYCLES < 1 || BLINK_DIV < 1) begin : g_param_invalido
        $fatal(1, "matriz_leds_cursor: parameter out of range");
    end

    logic [NUM_BOTOES-1:0]            w_pulso;
    logic [LINHAS-1:0][COLUNAS-1:0]   r_tab;
    logic [LINHAS-1:0][COLUNAS-1:0]   w_tab_prox;
    logic [LINHAS-1:0][COLUNAS-1:0]   w_mascara;
    logic [LINHAS-1:0][COLUNAS-1:0]   w_exibido;
    logic [LW-1:0]                    r_cur_lin;
    logic [LW-1:0]                    w_lin_prox;
    logic [CW-1:0]                    r_cur_col;
    logic [CW-1:0]                    w_col_prox;
    logic [2:0]                       r_nivel;
    logic [SW-1:0]                    r_presc;
    logic [LW-1:0]                    r_lin_scan;
    logic [LINHAS-1:0]                r_linhas;
    logic [COLUNAS-1:0]               r_colunas;
    logic                             r_concluido;
    logic                             w_vitoria;
    int                               w_alvo;
    int                               w_cl;
    int                               w_cc;

    for (genvar g = 0; g < NUM_BOTOES; g++) begin : g_deb
        debounce_botao #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .in    (botoes[g]),
            .pulso (w_pulso[g])
        );
    end

    assign w_cl = int'(r_cur_lin);
    assign w_cc = int'(r_cur_col);

    // Plus-shaped toggle mask; off-board neighbours simply never match a cell.
    always_comb begin
        w_mascara = '0;
        for (int l = 0; l < LINHAS; l++) begin
            for (int c = 0; c < COLUNAS; c++) begin
                w_mascara[l][c] = (l == w_cl && (c == w_cc || c == w_cc - 1 || c == w_cc + 1)) ||
                                  (c == w_cc && (l == w_cl - 1 || l == w_cl + 1));
            end
        end
    end

    always_comb begin
        w_tab_prox = r_tab;
        w_lin_prox = r_cur_lin;
        w_col_prox = r_cur_col;
        if (nivel != r_nivel) begin
            w_tab_prox = '0;
            w_lin_prox = '0;
            w_col_prox = '0;
        end else if (w_pulso[BTN_CLEAR]) begin
            w_tab_prox = '0;
        end else if (w_pulso[BTN_TOGGLE]) begin
            w_tab_prox = r_tab ^ w_mascara;
        end else begin
            if (w_pulso[BTN_CIMA] && !w_pulso[BTN_BAIXO] && r_cur_lin != '0)
                w_lin_prox = r_cur_lin - 1'b1;
            else if (w_pulso[BTN_BAIXO] && !w_pulso[BTN_CIMA] && r_cur_lin != LW'(LINHAS - 1))
                w_lin_prox = r_cur_lin + 1'b1;
            if (w_pulso[BTN_ESQ] && !w_pulso[BTN_DIR] && r_cur_col != '0)
                w_col_prox = r_cur_col - 1'b1;
            else if (w_pulso[BTN_DIR] && !w_pulso[BTN_ESQ] && r_cur_col != CW'(COLUNAS - 1))
                w_col_prox = r_cur_col + 1'b1;
        end
    end

    always_comb begin
        w_alvo    = linhas_alvo(r_nivel, LINHAS);
        w_vitoria = (w_alvo != 0);
        for (int l = 0; l < LINHAS; l++) begin
            if (l < w_alvo && r_tab[l] != '1)
                w_vitoria = 1'b0;
        end
    end

`ifdef MATRIZ_CURSOR_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] r_blink_cnt;
    logic          r_fase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_fase      <= 1'b0;
        end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_fase      <= ~r_fase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    always_comb begin
        w_exibido = r_tab;
        w_exibido[r_cur_lin][r_cur_col] = r_tab[r_cur_lin][r_cur_col] ^ r_fase;
    end
`else
    assign w_exibido = r_tab;
`endif

    // Row drive and column data come from one register stage so they switch together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tab       <= '0;
            r_cur_lin   <= '0;
            r_cur_col   <= '0;
            r_nivel     <= '0;
            r_presc     <= '0;
            r_lin_scan  <= '0;
            r_linhas    <= ~LINHAS'(1);
            r_colunas   <= '0;
            r_concluido <= 1'b0;
        end else begin
            r_tab       <= w_tab_prox;
            r_cur_lin   <= w_lin_prox;
            r_cur_col   <= w_col_prox;
            r_nivel     <= nivel;
            r_concluido <= w_vitoria;
            r_linhas    <= ~(LINHAS'(1) << r_lin_scan);
            r_colunas   <= w_exibido[r_lin_scan];
            if (r_presc == SW'(SCAN_DIV - 1)) begin
                r_presc    <= '0;
                r_lin_scan <= (r_lin_scan == LW'(LINHAS - 1)) ? '0 : r_lin_scan + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    assign nivel_concluido = r_concluido;
    assign linhas          = r_linhas;
    assign colunas         = r_colunas;
    assign cursor_linha    = r_cur_lin;
    assign cursor_coluna   = r_cur_col;

endmodule
